// File: rtl/reaction_pacer.sv
// Reaction-game controller: drives the speed counter's enable/speed, shows a one-hot
// target LED, scores correct presses and counts misses until the game ends.
module reaction_pacer #(
  parameter logic [3:0] MAX_MISS   = 4'd3,
  parameter logic [7:0] LVL2_SCORE = 8'd5,
  parameter logic [7:0] LVL3_SCORE = 8'd10,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] hit,
  input  logic       timeout,
  output logic       enable,
  output logic [1:0] speed,
  output logic [3:0] target,
  output logic [7:0] score,
  output logic [3:0] misses,
  output logic       game_over
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    OVER = 2'd3
  } state_t;

  state_t     state_r;
  logic [7:0] lfsr_r;
  logic       timeout_q_r;
  logic [3:0] prev_target_r;

  logic       to_evt_s;
  logic [3:0] next_target_s;
  logic [7:0] score_inc_s;
  logic [3:0] misses_inc_s;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [1:0] speed_of(input logic [7:0] s);
    logic [1:0] v;
    if (s >= LVL3_SCORE) begin
      v = 2'd2;
    end else if (s >= LVL2_SCORE) begin
      v = 2'd1;
    end else begin
      v = 2'd0;
    end
    return v;
  endfunction

  // Never repeat the previous LED: on a collision, rotate the candidate left by one.
  function automatic logic [3:0] pick_target(input logic [1:0] sel, input logic [3:0] prev);
    logic [3:0] cand;
    cand = 4'b0001 << sel;
    if (cand == prev) begin
      cand = {cand[2:0], cand[3]};
    end else begin
      cand = cand;
    end
    return cand;
  endfunction

  // Edge detect, target selection and saturating counters.
  always_comb begin
    to_evt_s      = timeout & ~timeout_q_r;
    next_target_s = pick_target(lfsr_r[1:0], prev_target_r);
    score_inc_s   = (score == 8'hFF) ? 8'hFF : score + 8'd1;
    misses_inc_s  = misses + 4'd1;
  end

  // Game state machine with registered outputs; LFSR and timeout edge register run always.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      lfsr_r        <= LFSR_SEED;
      timeout_q_r   <= 1'b0;
      prev_target_r <= 4'd0;
      enable        <= 1'b0;
      speed         <= 2'd0;
      target        <= 4'd0;
      score         <= 8'd0;
      misses        <= 4'd0;
      game_over     <= 1'b0;
    end else begin
      lfsr_r      <= lfsr_next(lfsr_r);
      timeout_q_r <= timeout;
      case (state_r)
        IDLE: begin
          if (start) begin
            score   <= 8'd0;
            misses  <= 4'd0;
            speed   <= 2'd0;
            state_r <= ARM;
          end
        end
        ARM: begin
          target        <= next_target_s;
          prev_target_r <= next_target_s;
          enable        <= 1'b1;
          state_r       <= RUN;
        end
        RUN: begin
          if (hit == target) begin
            score   <= score_inc_s;
            speed   <= speed_of(score_inc_s);
            enable  <= 1'b0;
            target  <= 4'd0;
            state_r <= ARM;
          end else if ((hit != 4'd0) || to_evt_s) begin
            misses <= misses_inc_s;
            enable <= 1'b0;
            target <= 4'd0;
            if (misses_inc_s == MAX_MISS) begin
              game_over <= 1'b1;
              state_r   <= OVER;
            end else begin
              state_r <= ARM;
            end
          end else begin
            state_r <= RUN;
          end
        end
        OVER: begin
          if (start) begin
            score     <= 8'd0;
            misses    <= 4'd0;
            speed     <= 2'd0;
            game_over <= 1'b0;
            state_r   <= ARM;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_pacer.sv
// Randomized self-checking bench for reaction_pacer against a game-level reference model.
module tb_reaction_pacer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] hit;
  logic       timeout;
  logic       enable;
  logic [1:0] speed;
  logic [3:0] target;
  logic [7:0] score;
  logic [3:0] misses;
  logic       game_over;

  int n_checks = 0;
  int n_errors = 0;

  localparam int P_IDLE = 0;
  localparam int P_ARM  = 1;
  localparam int P_RUN  = 2;
  localparam int P_OVER = 3;
  localparam int MAXM   = 3;

  int         m_phase;
  int         m_score;
  int         m_misses;
  logic [3:0] m_target;
  logic [3:0] m_prev;
  logic [7:0] m_lfsr;
  logic       m_to_q;
  logic       m_go;

  reaction_pacer dut (
    .clk(clk), .rst(rst), .start(start), .hit(hit), .timeout(timeout),
    .enable(enable), .speed(speed), .target(target), .score(score),
    .misses(misses), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = P_IDLE;
    m_score  = 0;
    m_misses = 0;
    m_target = 4'd0;
    m_prev   = 4'd0;
    m_lfsr   = 8'hA5;
    m_to_q   = 1'b0;
    m_go     = 1'b0;
  endtask

  function automatic int exp_speed(input int s);
    return (s >= 10) ? 2 : ((s >= 5) ? 1 : 0);
  endfunction

  task automatic check_all();
    check_val("enable", 32'(enable), 32'(m_phase == P_RUN));
    check_val("target", 32'(target), (m_phase == P_RUN) ? 32'(m_target) : 32'd0);
    check_val("score", 32'(score), 32'(m_score));
    check_val("misses", 32'(misses), 32'(m_misses));
    check_val("speed", 32'(speed), 32'(exp_speed(m_score)));
    check_val("game_over", 32'(game_over), 32'(m_go));
  endtask

  // Advance the reference model by one clock given the inputs applied for that clock.
  task automatic model_step(input logic s, input logic [3:0] h, input logic t);
    logic       evt;
    logic [3:0] c;
    evt = t & ~m_to_q;
    m_to_q = t;
    case (m_phase)
      P_IDLE, P_OVER: begin
        if (s) begin
          m_score = 0; m_misses = 0; m_go = 1'b0; m_phase = P_ARM;
        end
      end
      P_ARM: begin
        c = 4'(1 << m_lfsr[1:0]);
        if (c == m_prev) c = ((c << 1) | (c >> 3)) & 4'hF;
        m_target = c; m_prev = c; m_phase = P_RUN;
      end
      default: begin
        if (h == m_target) begin
          m_score = (m_score + 1 > 255) ? 255 : m_score + 1;
          m_phase = P_ARM;
        end else if (h != 4'd0 || evt) begin
          m_misses++;
          if (m_misses == MAXM) begin
            m_phase = P_OVER; m_go = 1'b1;
          end else begin
            m_phase = P_ARM;
          end
        end
      end
    endcase
    m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  endtask

  task automatic step(input logic s, input logic [3:0] h, input logic t);
    start = s; hit = h; timeout = t;
    model_step(s, h, t);
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_run();
    for (int i = 0; i < 6 && m_phase != P_RUN; i++) step(1'b0, 4'd0, 1'b0);
  endtask

  task automatic hit_target();
    wait_run();
    step(1'b0, m_target, 1'b0);
  endtask

  task automatic held_timeout();
    wait_run();
    for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    logic [3:0] h;
    logic       s;
    logic       t;
    int         r;
    rst = 1'b0; start = 1'b0; hit = 4'd0; timeout = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b1;

    // Start, then five correct hits take speed from 0 to 1.
    step(1'b0, 4'd0, 1'b0);
    step(1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) hit_target();

    // Hit and rising timeout together: the hit wins.
    wait_run();
    step(1'b0, m_target, 1'b1);
    step(1'b0, 4'd0, 1'b0);

    // Three held timeouts, one miss each, end the game.
    for (int i = 0; i < 3; i++) held_timeout();
    for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 1'b0);

    // Restart, a multi-button press is a miss, then play to saturation.
    step(1'b1, 4'd0, 1'b0);
    wait_run();
    step(1'b0, 4'b0011, 1'b0);
    for (int i = 0; i < 258; i++) hit_target();

    // Asynchronous reset mid-run.
    wait_run();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    rst = 1'b1;

    // A short game into OVER, then start restarts at score 0.
    step(1'b1, 4'd0, 1'b0);
    hit_target();
    hit_target();
    for (int i = 0; i < 3; i++) begin
      wait_run();
      step(1'b0, 4'b1111, 1'b0);
    end
    step(1'b0, 4'd0, 1'b0);
    step(1'b1, 4'd0, 1'b0);

    // Random play.
    t = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 7);
      if (r < 3 && m_phase == P_RUN) begin
        h = m_target;
      end else if (r == 3) begin
        h = 4'($urandom_range(1, 15));
      end else begin
        h = 4'd0;
      end
      if ($urandom_range(0, 5) == 0) t = ~t;
      step(s, h, t);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reaction_pacer.md
Name: reaction_pacer

Overview:
- Game-level controller at the consuming end of the speed-interval counter interface.
- Drives that counter's enable and 2-bit speed select, and consumes its timeout output.
- Presents a one-hot target LED, scores correct player presses, counts misses (timeouts and wrong presses), and raises speed as the score grows.
- Ends the game after a set number of misses.

Parameters:
- MAX_MISS, 3, number of misses that ends the game (1..15).
- LVL2_SCORE, 5, score at or above which speed = 1.
- LVL3_SCORE, 10, score at or above which speed = 2; must exceed LVL2_SCORE.
- LFSR_SEED, 8'hA5, LFSR value loaded on reset; must be nonzero.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins or restarts a game.
- hit  in  4  single-cycle button pulses, one bit per target LED.
- timeout  in  1  interval-expired level from the speed counter.
- enable  out  1  run enable to the speed counter.
- speed  out  2  interval select to the speed counter (0 = 1.0 s, 1 = 0.7 s, 2 = 0.4 s; 3 never driven).
- target  out  4  one-hot active LED; 0 when not running.
- score  out  8  correct hits this game, saturating at 255.
- misses  out  4  misses this game.
- game_over  out  1  high while in OVER.

Behaviour:
- Reset (asynchronous, rst=0):
  - state = IDLE, LFSR = LFSR_SEED, timeout edge register = 0.
  - All outputs are 0, including target and prev_target.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4, advances every clk in every state.
  - Candidate target = one-hot of lfsr[1:0].
  - If the candidate equals prev_target, target = rotate-left-by-1 of the candidate instead.
- Timeout sensing:
  - timeout can stay high for multiple cycles.
  - Only the rising edge counts: to_evt = timeout & ~timeout_q.
- States:
  - IDLE:
    - enable = 0, target = 0.
    - start → clear score and misses → ARM.
  - ARM (exactly 1 cycle):
    - enable = 0. This forces the speed counter to restart its interval on the next cycle.
    - Load target from the LFSR rule; prev_target <= new target.
    - → RUN.
  - RUN:
    - enable = 1. Events are evaluated in this priority order:
    - (a) hit == target: score <= score+1 (saturating) → ARM.
    - (b) hit nonzero and != target (wrong press or multiple buttons): misses <= misses+1 → ARM.
    - (c) to_evt: misses <= misses+1 → ARM.
    - Transition to OVER: if the post-increment misses == MAX_MISS, go to OVER instead of ARM.
    - hit and to_evt in the same cycle: the hit is evaluated and the timeout is ignored.
    - start in RUN is ignored.
  - OVER:
    - enable = 0, target = 0, game_over = 1.
    - score and misses hold.
    - start → clear score, misses and game_over → ARM.
- speed:
  - Registered, updated whenever score changes.
  - score >= LVL3_SCORE → 2; else score >= LVL2_SCORE → 1; else 0.
  - The new speed is valid before the next ARM releases enable.
- Latency:
  - Correct hit in cycle n → score updated and ARM in cycle n+1 → new target and enable = 1 in cycle n+2.
- Reset mid-game: immediate return to the reset values; there is no partial state.

Test Plan:
1. Reset, then start pulse → ARM for 1 cycle with enable = 0, then RUN with enable = 1, target one-hot derived from seed 8'hA5, score = 0, misses = 0.
2. Five consecutive hit == target presses → score = 5, speed goes 0 → 1 after the 5th hit, enable low for exactly 1 cycle between targets, no two consecutive equal targets.
3. Hold timeout high for 4 cycles during RUN → misses increments by exactly 1; three such timeouts → game_over = 1, enable = 0, target = 0, score held.
4. In the same cycle, hit == target and timeout rising → score +1, misses unchanged.
5. Press hit = 4'b0011 while target = 4'b0001 → counted as a miss; reach score 10 → speed = 2; force score to 255 and hit again → score stays 255.
6. Assert rst low mid-RUN, asynchronously between clock edges → all outputs 0 immediately; start in OVER restarts with score = 0.
